regfile_scan_reader: RTL

- Read-side initiator for the core's debug register-read port (read_addr valid/ready request, read_data valid/ready response).
- On `start`, sweeps a contiguous window of register addresses and issues one read per address.
- Collects the responses in order and streams each as an {address, data} pair to a host-side output port.
- Keeps a running XOR checksum and pulses `done` when the sweep completes. Used by the testbench host and scan/debug logic to dump architectural state.

---
 rtl/regfile_scan_reader.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/regfile_scan_reader.sv
// regfile_scan_reader: sweeps a window of register addresses over the debug
// read port, collects responses in order, and streams {address, data} pairs
// to the host. A running XOR checksum covers the sweep; done pulses at the end.
module regfile_scan_reader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              protocol_err,
  output logic [DATA_W-1:0] checksum,
  output logic              rd_addr_valid,
  input  logic              rd_addr_ready,
  output logic [ADDR_W-1:0] rd_addr_bits,
  input  logic              rd_data_valid,
  output logic              rd_data_ready,
  input  logic [DATA_W-1:0] rd_data_bits,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data
);

  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;
  localparam int CNT_W = ADDR_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CW-1:0]    DEPTH_C   = CW'(DEPTH);
  localparam logic [CW:0]      DEPTH_SUM = (CW + 1)'(DEPTH);

  logic [1:0]        state, state_next;
  logic [ADDR_W-1:0] base_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  issued, received, popped, popped_next;
  logic [CW-1:0]     outstanding, fifo_count;
  logic [PW-1:0]     wr_ptr, rd_ptr, tq_wr, tq_rd;
  logic [DATA_W-1:0] checksum_reg;
  logic              protocol_err_reg;

  // Response buffer and in-order address-tag queue, both plain register arrays
  logic [ADDR_W-1:0] buf_addr [DEPTH];
  logic [DATA_W-1:0] buf_data [DEPTH];
  logic [ADDR_W-1:0] tag_mem  [DEPTH];

  logic start_accept, credit_ok, addr_fire, data_fire, out_fire;
  logic unsolicited, push;
  logic [ADDR_W-1:0] push_tag;

  assign start_accept  = (state == S_IDLE) && start;
  assign busy          = (state != S_IDLE);
  assign done          = (state == S_DONE);
  assign credit_ok     = ({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_SUM;
  assign rd_addr_valid = (state == S_ISSUE) && (issued < count_reg) && credit_ok;
  assign rd_addr_bits  = base_reg + issued[ADDR_W-1:0];
  assign rd_data_ready = busy && (fifo_count < DEPTH_C);
  assign out_valid     = (fifo_count != '0);
  assign out_addr      = buf_addr[rd_ptr];
  assign out_data      = buf_data[rd_ptr];
  assign checksum      = checksum_reg;
  assign protocol_err  = protocol_err_reg;

  assign addr_fire   = rd_addr_valid && rd_addr_ready;
  assign data_fire   = rd_data_valid && rd_data_ready;
  assign out_fire    = out_valid && out_ready;
  // A response with nothing in flight and no request firing alongside it is dropped
  assign unsolicited = data_fire && (outstanding == '0) && !addr_fire;
  assign push        = data_fire && !unsolicited;
  // With nothing outstanding, a legal response must belong to the request firing now
  assign push_tag    = (outstanding == '0) ? rd_addr_bits : tag_mem[tq_rd];
  assign popped_next = popped + (out_fire ? CNT_ONE : '0);

  // Sweep sequencing
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) state_next = (count == '0) ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        if (addr_fire && ((issued + CNT_ONE) == count_reg)) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if ((received == count_reg) && (popped_next == count_reg)) state_next = S_DONE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Control state, counters, pointers and checksum
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= S_IDLE;
      base_reg         <= '0;
      count_reg        <= '0;
      issued           <= '0;
      received         <= '0;
      popped           <= '0;
      outstanding      <= '0;
      fifo_count       <= '0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      tq_wr            <= '0;
      tq_rd            <= '0;
      checksum_reg     <= '0;
      protocol_err_reg <= 1'b0;
    end else begin
      state       <= state_next;
      outstanding <= outstanding + CW'(addr_fire) - CW'(push);
      fifo_count  <= fifo_count + CW'(push) - CW'(out_fire);
      if (start_accept) begin
        base_reg         <= base_addr;
        count_reg        <= count;
        issued           <= '0;
        received         <= '0;
        popped           <= '0;
        checksum_reg     <= '0;
        protocol_err_reg <= 1'b0;
      end else begin
        if (addr_fire) begin
          issued <= issued + CNT_ONE;
          tq_wr  <= tq_wr + PW'(1);
        end
        if (push) begin
          received     <= received + CNT_ONE;
          checksum_reg <= checksum_reg ^ rd_data_bits;
          wr_ptr       <= wr_ptr + PW'(1);
          tq_rd        <= tq_rd + PW'(1);
        end
        if (out_fire) begin
          popped <= popped_next;
          rd_ptr <= rd_ptr + PW'(1);
        end
        if (unsolicited) protocol_err_reg <= 1'b1;
      end
    end
  end

  // Storage writes: tags on request, {tag, data} on accepted response
  always_ff @(posedge clk) begin
    if (addr_fire) tag_mem[tq_wr] <= rd_addr_bits;
    if (push) begin
      buf_addr[wr_ptr] <= push_tag;
      buf_data[wr_ptr] <= rd_data_bits;
    end
  end

endmodule
